hazard_controller: RTL and testbench

- Central hazard and sequencing controller for the 5-stage pipelined MIPS core.
- Drives stall, enable and clear controls for the IF/ID, ID/EX and EX/MEM pipeline registers.
- Generates the EX-stage and ID-stage forwarding selects.
- Sequences a multi-cycle MUL/DIV unit in execute through a small FSM and cycle counter. It holds the pipeline until the result is ready.

---
 rtl/hazard_if.sv | 36 +++
 rtl/hazard_controller.sv | 110 +++++++++++
 tb/tb_hazard_controller.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_if.sv
// =============================================================================
// hazard_if : pipeline hazard-control bundle between datapath and controller
// Rev 1.0
// =============================================================================
`default_nettype none

interface hazard_if;
  logic [4:0] RsD, RtD, RsE, RtE;
  logic [4:0] WriteRegE, WriteRegM, WriteRegW;
  logic       RegWriteE, RegWriteM, RegWriteW;
  logic       MemtoRegE, MemtoRegM;
  logic       BranchD, PCSrcD;
  logic       MdStartE, MdIsDivE;
  logic       StallF, StallD, FlushD, StallE, FlushE, FlushM;
  logic [1:0] ForwardAE, ForwardBE;
  logic       ForwardAD, ForwardBD;
  logic       MdBusy, MdDone;

  modport slave (
    input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
           RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
           BranchD, PCSrcD, MdStartE, MdIsDivE,
    output StallF, StallD, FlushD, StallE, FlushE, FlushM,
           ForwardAE, ForwardBE, ForwardAD, ForwardBD, MdBusy, MdDone
  );

  modport master (
    output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
           RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
           BranchD, PCSrcD, MdStartE, MdIsDivE,
    input  StallF, StallD, FlushD, StallE, FlushE, FlushM,
           ForwardAE, ForwardBE, ForwardAD, ForwardBD, MdBusy, MdDone
  );
endinterface

`default_nettype wire

// File: rtl/hazard_controller.sv
// =============================================================================
// hazard_controller : stall/flush/forward control and MUL/DIV sequencing
// Rev 1.0
// =============================================================================
`default_nettype none

module hazard_controller #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic     clk,
  input  logic     rst_n,
  hazard_if.slave  hz
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] C_MUL_LOAD = CNT_WIDTH'(MUL_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] C_DIV_LOAD = CNT_WIDTH'(DIV_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] C_CNT_ONE  = CNT_WIDTH'(1);

  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_cnt;

  // Register $0 is hardwired to zero, so it can never create a dependency.
  function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

  logic       w_lwstall, w_brstall, w_mdstall, w_stall_fd;
  logic [1:0] w_fwd_ae, w_fwd_be;
  logic       w_fwd_ad, w_fwd_bd;

  always_comb begin
    w_fwd_ae = 2'b00;
    if (hz.RegWriteM && reg_match(hz.WriteRegM, hz.RsE))
      w_fwd_ae = 2'b10;
    else if (hz.RegWriteW && reg_match(hz.WriteRegW, hz.RsE))
      w_fwd_ae = 2'b01;

    w_fwd_be = 2'b00;
    if (hz.RegWriteM && reg_match(hz.WriteRegM, hz.RtE))
      w_fwd_be = 2'b10;
    else if (hz.RegWriteW && reg_match(hz.WriteRegW, hz.RtE))
      w_fwd_be = 2'b01;
  end

  assign w_fwd_ad = hz.RegWriteM && reg_match(hz.WriteRegM, hz.RsD);
  assign w_fwd_bd = hz.RegWriteM && reg_match(hz.WriteRegM, hz.RtD);

  assign w_lwstall = hz.MemtoRegE &&
                     (reg_match(hz.RtE, hz.RsD) || reg_match(hz.RtE, hz.RtD));

  assign w_brstall = hz.BranchD && (
                       (hz.RegWriteE && (reg_match(hz.WriteRegE, hz.RsD) ||
                                         reg_match(hz.WriteRegE, hz.RtD))) ||
                       (hz.MemtoRegM && (reg_match(hz.WriteRegM, hz.RsD) ||
                                         reg_match(hz.WriteRegM, hz.RtD))));

  // DONE deliberately drops the stall: the finished instruction leaves E now.
  assign w_mdstall = ((r_state == S_IDLE) && hz.MdStartE) || (r_state == S_BUSY);

  assign w_stall_fd = w_lwstall || w_brstall || w_mdstall;

  // Every output is held low while reset is asserted, independent of inputs.
  assign hz.StallF    = rst_n && w_stall_fd;
  assign hz.StallD    = rst_n && w_stall_fd;
  assign hz.FlushD    = rst_n && hz.PCSrcD && !w_stall_fd;
  assign hz.StallE    = rst_n && w_mdstall;
  assign hz.FlushM    = rst_n && w_mdstall;
  assign hz.FlushE    = rst_n && (w_lwstall || w_brstall) && !w_mdstall;
  assign hz.ForwardAE = rst_n ? w_fwd_ae : 2'b00;
  assign hz.ForwardBE = rst_n ? w_fwd_be : 2'b00;
  assign hz.ForwardAD = rst_n && w_fwd_ad;
  assign hz.ForwardBD = rst_n && w_fwd_bd;
  assign hz.MdBusy    = rst_n && (r_state == S_BUSY);
  assign hz.MdDone    = rst_n && (r_state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (hz.MdStartE) begin
            r_cnt   <= hz.MdIsDivE ? C_DIV_LOAD : C_MUL_LOAD;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (r_cnt == C_CNT_ONE)
            r_state <= S_DONE;
          else
            r_cnt <= r_cnt - C_CNT_ONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hazard_controller.sv
// =============================================================================
// tb_hazard_controller : scoreboard-driven bench for hazard_controller
// Rev 1.0
// =============================================================================
`default_nettype none

module tb_hazard_controller;

  logic clk;
  logic rst_n;
  int   passed;
  int   total;

  logic [13:0] exp_q[$];
  logic [13:0] got;
  logic [13:0] expv;

  hazard_if hz ();

  hazard_controller #(
    .MUL_CYCLES (4),
    .DIV_CYCLES (32),
    .CNT_WIDTH  (6)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  function automatic logic [13:0] ev(input logic sf, sd, fd, se, fe, fm,
                                     input logic [1:0] fae, fbe,
                                     input logic fad, fbd, busy, done);
    return {sf, sd, fd, se, fe, fm, fae, fbe, fad, fbd, busy, done};
  endfunction

  function automatic logic [13:0] outs();
    return {hz.StallF, hz.StallD, hz.FlushD, hz.StallE, hz.FlushE, hz.FlushM,
            hz.ForwardAE, hz.ForwardBE, hz.ForwardAD, hz.ForwardBD,
            hz.MdBusy, hz.MdDone};
  endfunction

  task automatic clear_inputs();
    hz.RsD = 0; hz.RtD = 0; hz.RsE = 0; hz.RtE = 0;
    hz.WriteRegE = 0; hz.WriteRegM = 0; hz.WriteRegW = 0;
    hz.RegWriteE = 0; hz.RegWriteM = 0; hz.RegWriteW = 0;
    hz.MemtoRegE = 0; hz.MemtoRegM = 0;
    hz.BranchD = 0; hz.PCSrcD = 0; hz.MdStartE = 0; hz.MdIsDivE = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    hz.RegWriteM = 1; hz.WriteRegM = 5; hz.RsE = 5; hz.MdStartE = 1;
    hz.BranchD = 1; hz.PCSrcD = 1;
    exp_q.push_back(14'd0);
    #3;
    got = outs(); expv = exp_q.pop_front(); total++;
    if (got !== expv) $display("FAIL reset_outputs got=%b exp=%b", got, expv); else passed++;
    next_cycle();
    rst_n = 1'b1;
    clear_inputs();
    exp_q.push_back(14'd0);
    @(negedge clk);
    got = outs(); expv = exp_q.pop_front(); total++;
    if (got !== expv) $display("FAIL reset_release_idle got=%b exp=%b", got, expv); else passed++;
    next_cycle();
  endtask

  task automatic test_forwarding();
    clear_inputs();
    hz.RegWriteM = 1; hz.WriteRegM = 5; hz.RegWriteW = 1; hz.WriteRegW = 5; hz.RsE = 5;
    exp_q.push_back(ev(0,0,0,0,0,0, 2'b10, 2'b00, 0,0,0,0));
    @(negedge clk);
    got = outs(); expv = exp_q.pop_front(); total++;
    if (got !== expv) $display("FAIL fwd_mem_priority got=%b exp=%b", got, expv); else passed++;
    next_cycle();

    hz.RegWriteM = 0; hz.RtE = 5;
    exp_q.push_back(ev(0,0,0,0,0,0, 2'b01, 2'b01, 0,0,0,0));
    @(negedge clk);
    got = outs(); expv = exp_q.pop_front(); total++;
    if (got !== expv) $display("FAIL fwd_wb got=%b exp=%b", got, expv); else passed++;
    next_cycle();

    hz.RegWriteM = 1; hz.WriteRegM = 0; hz.WriteRegW = 0; hz.RsE = 0; hz.RtE = 0;
    exp_q.push_back(14'd0);
    @(negedge clk);
    got = outs(); expv = exp_q.pop_front(); total++;
    if (got !== expv) $display("FAIL fwd_reg0 got=%b exp=%b", got, expv); else passed++;
    next_cycle();

    hz.WriteRegM = 7; hz.RtD = 7; hz.RtE = 7; hz.RsD = 9;
    exp_q.push_back(ev(0,0,0,0,0,0, 2'b00, 2'b10, 0,1,0,0));
    @(negedge clk);
    got = outs(); expv = exp_q.pop_front(); total++;
    if (got !== expv) $display("FAIL fwd_bd_be got=%b exp=%b", got, expv); else passed++;
    next_cycle();
  endtask

  task automatic test_load_use();
    clear_inputs();
    hz.MemtoRegE = 1; hz.RtE = 8; hz.RsD = 8;
    exp_q.push_back(ev(1,1,0,0,1,0, 2'b00, 2'b00, 0,0,0,0));
    @(negedge clk);
    got = outs(); expv = exp_q.pop_front(); total++;
    if (got !== expv) $display("FAIL load_use_stall got=%b exp=%b", got, expv); else passed++;
    next_cycle();

    hz.MemtoRegE = 0;
    exp_q.push_back(14'd0);
    @(negedge clk);
    got = outs(); expv = exp_q.pop_front(); total++;
    if (got !== expv) $display("FAIL load_use_clear got=%b exp=%b", got, expv); else passed++;
    next_cycle();

    hz.MemtoRegE = 1; hz.RtE = 0; hz.RsD = 0; hz.RtD = 0;
    exp_q.push_back(14'd0);
    @(negedge clk);
    got = outs(); expv = exp_q.pop_front(); total++;
    if (got !== expv) $display("FAIL load_use_reg0 got=%b exp=%b", got, expv); else passed++;
    next_cycle();
  endtask

  task automatic test_branch();
    clear_inputs();
    hz.BranchD = 1; hz.RsD = 3; hz.RegWriteE = 1; hz.WriteRegE = 3;
    exp_q.push_back(ev(1,1,0,0,1,0, 2'b00, 2'b00, 0,0,0,0));
    @(negedge clk);
    got = outs(); expv = exp_q.pop_front(); total++;
    if (got !== expv) $display("FAIL branch_alu_stall got=%b exp=%b", got, expv); else passed++;
    next_cycle();

    hz.RegWriteE = 0; hz.MemtoRegM = 1; hz.WriteRegM = 3;
    exp_q.push_back(ev(1,1,0,0,1,0, 2'b00, 2'b00, 0,0,0,0));
    @(negedge clk);
    got = outs(); expv = exp_q.pop_front(); total++;
    if (got !== expv) $display("FAIL branch_load_stall got=%b exp=%b", got, expv); else passed++;
    next_cycle();

    hz.PCSrcD = 1;
    exp_q.push_back(ev(1,1,0,0,1,0, 2'b00, 2'b00, 0,0,0,0));
    @(negedge clk);
    got = outs(); expv = exp_q.pop_front(); total++;
    if (got !== expv) $display("FAIL branch_no_flushd_stalled got=%b exp=%b", got, expv); else passed++;
    next_cycle();

    hz.PCSrcD = 0; hz.MemtoRegM = 0; hz.RegWriteM = 1;
    exp_q.push_back(ev(0,0,0,0,0,0, 2'b00, 2'b00, 1,0,0,0));
    @(negedge clk);
    got = outs(); expv = exp_q.pop_front(); total++;
    if (got !== expv) $display("FAIL branch_fwd_ad got=%b exp=%b", got, expv); else passed++;
    next_cycle();

    hz.PCSrcD = 1;
    exp_q.push_back(ev(0,0,1,0,0,0, 2'b00, 2'b00, 1,0,0,0));
    @(negedge clk);
    got = outs(); expv = exp_q.pop_front(); total++;
    if (got !== expv) $display("FAIL branch_flushd got=%b exp=%b", got, expv); else passed++;
    next_cycle();
    clear_inputs();
  endtask

  // Drives n stall cycles plus the DONE cycle; stop_after>=0 aborts early.
  task automatic run_md(input int n, input bit isdiv, input bit lw,
                        input int stop_after, input string tag);
    for (int c = 0; c <= n; c++) begin
      if (c == stop_after) return;
      clear_inputs();
      hz.MdStartE = 1;
      hz.MdIsDivE = (c == 0) ? isdiv : !isdiv;
      if (lw && c < n) begin
        hz.MemtoRegE = 1; hz.RtE = 8; hz.RsD = 8;
      end
      if (c < n)
        exp_q.push_back(ev(1,1,0,1,0,1, 2'b00, 2'b00, 0,0, (c > 0), 0));
      else
        exp_q.push_back(ev(0,0,0,0,0,0, 2'b00, 2'b00, 0,0,0,1));
      @(negedge clk);
      got = outs(); expv = exp_q.pop_front(); total++;
      if (got !== expv) $display("FAIL %s cycle=%0d got=%b exp=%b", tag, c, got, expv);
      else passed++;
      next_cycle();
    end
  endtask

  task automatic test_idle_after_md(input string tag);
    clear_inputs();
    exp_q.push_back(14'd0);
    @(negedge clk);
    got = outs(); expv = exp_q.pop_front(); total++;
    if (got !== expv) $display("FAIL %s_idle got=%b exp=%b", tag, got, expv); else passed++;
    next_cycle();
  endtask

  task automatic test_multiply();
    run_md(4, 1'b0, 1'b0, -1, "mul");
    test_idle_after_md("mul");
  endtask

  task automatic test_back_to_back();
    run_md(32, 1'b1, 1'b1, -1, "div");
    run_md(4, 1'b0, 1'b0, -1, "mul_after_div");
    test_idle_after_md("b2b");
  endtask

  task automatic test_reset_mid_div();
    run_md(32, 1'b1, 1'b0, 22, "div_pre_reset");
    clear_inputs();
    hz.MdStartE = 1; hz.MdIsDivE = 1;
    #2;
    rst_n = 1'b0;
    exp_q.push_back(14'd0);
    #1;
    got = outs(); expv = exp_q.pop_front(); total++;
    if (got !== expv) $display("FAIL reset_mid_div got=%b exp=%b", got, expv); else passed++;
    next_cycle();
    rst_n = 1'b1;
    run_md(32, 1'b1, 1'b0, -1, "div_after_reset");
    test_idle_after_md("div_after_reset");
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_multiply();
    test_back_to_back();
    test_reset_mid_div();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
